// File: rtl/tile_control_unit_pkg.sv
// Shared types and helpers for the tile control unit: FSM state encoding,
// operand select encoding and a width helper.
package tile_control_unit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_RD = 3'd1,
        LOAD   = 3'd2,
        RUN_PU = 3'd3,
        REQ_WR = 3'd4,
        STORE  = 3'd5
    } state_e;

    localparam logic AORB_A = 1'b0;
    localparam logic AORB_B = 1'b1;

    // ceil(log2(v)), never less than 1 so a K=1 tile still gets a counter bit
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/tile_control_unit_addr_gen.sv
// Combinational element address: base + (p*K + r)*N + q*K + c, N = mu*K,
// wrapping modulo 2^MEM_ADDR_WIDTH.
module tile_addr_gen
    import tile_control_unit_pkg::*;
#(
    parameter int K              = 2,
    parameter int INDEX_WIDTH    = 8,
    parameter int MU_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH      = clog2(K * K)
) (
    input  logic [MEM_ADDR_WIDTH-1:0] i_base,
    input  logic [INDEX_WIDTH-1:0]    i_tile_row,
    input  logic [INDEX_WIDTH-1:0]    i_tile_col,
    input  logic [MU_WIDTH-1:0]       i_mu,
    input  logic [CNT_WIDTH-1:0]      i_elem,
    output logic [MEM_ADDR_WIDTH-1:0] o_addr
);
    localparam logic [CNT_WIDTH-1:0]      K_C = CNT_WIDTH'(K);
    localparam logic [MEM_ADDR_WIDTH-1:0] K_A = MEM_ADDR_WIDTH'(K);

    logic [CNT_WIDTH-1:0]      elem_r, elem_c;
    logic [MEM_ADDR_WIDTH-1:0] row_len, row, col;

    always_comb begin
        elem_r  = i_elem / K_C;
        elem_c  = i_elem % K_C;
        row_len = MEM_ADDR_WIDTH'(i_mu) * K_A;
        row     = MEM_ADDR_WIDTH'(i_tile_row) * K_A + MEM_ADDR_WIDTH'(elem_r);
        col     = MEM_ADDR_WIDTH'(i_tile_col) * K_A + MEM_ADDR_WIDTH'(elem_c);
        o_addr  = i_base + row * row_len + col;
    end

endmodule

// File: rtl/tile_control_unit.sv
// Sequences one C(i,j) tile: for each x loads A(i,x) and B(x,j) into the RF,
// runs the PU, then stores the accumulated tile to memory.
module tile_control_unit
    import tile_control_unit_pkg::*;
#(
    parameter int K              = 2,
    parameter int INDEX_WIDTH    = 8,
    parameter int MU_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH      = clog2(K * K)
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Grant,
    output logic                      o_Grant_Request,
    input  logic [INDEX_WIDTH-1:0]    i_Row_Index,
    input  logic [INDEX_WIDTH-1:0]    i_Column_Index,
    input  logic                      i_Indexes_Ready,
    output logic                      o_Indexes_Received,
    output logic                      o_Result_Ready,
    output logic                      o_Busy,
    input  logic [MU_WIDTH-1:0]       i_mu,
    input  logic [MEM_ADDR_WIDTH-1:0] i_A_Base,
    input  logic [MEM_ADDR_WIDTH-1:0] i_B_Base,
    input  logic [MEM_ADDR_WIDTH-1:0] i_C_Base,
    output logic [CNT_WIDTH-1:0]      o_RF_Address,
    output logic                      o_RF_Write_Enable,
    output logic                      o_RF_Read_Enable,
    output logic                      o_AorB,
    output logic                      o_PU_Start,
    output logic                      o_PU_First,
    input  logic                      i_Partial_Output_Ready,
    output logic                      o_Memory_Read_Enable,
    output logic                      o_Memory_Write_Enable,
    output logic [MEM_ADDR_WIDTH-1:0] o_Memory_Address
);
    localparam logic [CNT_WIDTH-1:0] LAST_ELEM = CNT_WIDTH'(K * K - 1);

    state_e                    state_q, state_d;
    logic [INDEX_WIDTH-1:0]    row_q, row_d, col_q, col_d;
    logic [MU_WIDTH-1:0]       mu_q, mu_d, x_q, x_d;
    logic [MEM_ADDR_WIDTH-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d, rd_elem_q, rd_elem_d;
    logic                      sel_q, sel_d, rd_sel_q, rd_sel_d;
    logic                      issue_done_q, issue_done_d, rd_last_q, rd_last_d, last_q, last_d;

    logic                      grant_req_q, grant_req_d, ack_q, ack_d, done_q, done_d, busy_q, busy_d;
    logic [CNT_WIDTH-1:0]      rf_addr_q, rf_addr_d;
    logic                      rf_we_q, rf_we_d, rf_re_q, rf_re_d, aorb_q, aorb_d;
    logic                      pu_start_q, pu_start_d, pu_first_q, pu_first_d;
    logic                      mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [MEM_ADDR_WIDTH-1:0] gen_base, gen_addr;
    logic [INDEX_WIDTH-1:0]    gen_tile_row, gen_tile_col;
    logic [CNT_WIDTH-1:0]      gen_elem;

    // STORE addresses the element leaving the RF; loads address the next element to issue
    always_comb begin
        gen_elem = count_q;
        if (state_q == STORE) begin
            gen_base = c_base_q; gen_tile_row = row_q; gen_tile_col = col_q; gen_elem = rf_addr_q;
        end else if (sel_q == AORB_A) begin
            gen_base = a_base_q; gen_tile_row = row_q; gen_tile_col = INDEX_WIDTH'(x_q);
        end else begin
            gen_base = b_base_q; gen_tile_row = INDEX_WIDTH'(x_q); gen_tile_col = col_q;
        end
    end

    tile_addr_gen #(
        .K(K), .INDEX_WIDTH(INDEX_WIDTH), .MU_WIDTH(MU_WIDTH),
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) u_addr_gen (
        .i_base(gen_base), .i_tile_row(gen_tile_row), .i_tile_col(gen_tile_col),
        .i_mu(mu_q), .i_elem(gen_elem), .o_addr(gen_addr)
    );

    always_comb begin
        state_d = state_q; row_d = row_q; col_d = col_q; mu_d = mu_q; x_d = x_q;
        a_base_d = a_base_q; b_base_d = b_base_q; c_base_d = c_base_q;
        count_d = count_q; sel_d = sel_q; issue_done_d = issue_done_q;
        rd_elem_d = '0; rd_sel_d = 1'b0; rd_last_d = 1'b0; last_d = 1'b0;
        grant_req_d = grant_req_q; busy_d = busy_q; ack_d = 1'b0; done_d = 1'b0;
        rf_addr_d = '0; rf_we_d = 1'b0; rf_re_d = 1'b0; aorb_d = 1'b0;
        pu_start_d = 1'b0; pu_first_d = 1'b0;
        mem_re_d = 1'b0; mem_we_d = 1'b0; mem_addr_d = '0;

        // one-cycle latency stages finish regardless of grant
        if (mem_re_q) begin
            rf_we_d = 1'b1; rf_addr_d = rd_elem_q; aorb_d = rd_sel_q; last_d = rd_last_q;
        end
        if (rf_re_q) begin
            mem_we_d = 1'b1; mem_addr_d = gen_addr; last_d = (rf_addr_q == LAST_ELEM);
        end

        case (state_q)
            IDLE: if (i_Indexes_Ready) begin
                row_d = i_Row_Index; col_d = i_Column_Index;
                mu_d = (i_mu == '0) ? MU_WIDTH'(1) : i_mu;
                a_base_d = i_A_Base; b_base_d = i_B_Base; c_base_d = i_C_Base;
                x_d = '0; ack_d = 1'b1; busy_d = 1'b1; grant_req_d = 1'b1;
                state_d = REQ_RD;
            end
            REQ_RD: if (i_Grant) begin
                state_d = LOAD; sel_d = AORB_A; count_d = '0; issue_done_d = 1'b0;
            end
            LOAD: begin
                if (i_Grant && !issue_done_q) begin
                    mem_re_d = 1'b1; mem_addr_d = gen_addr;
                    rd_elem_d = count_q; rd_sel_d = sel_q;
                    rd_last_d = (sel_q == AORB_B) && (count_q == LAST_ELEM);
                    if (count_q == LAST_ELEM) begin
                        count_d = '0;
                        if (sel_q == AORB_A) sel_d = AORB_B;
                        else issue_done_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
                if (last_q) begin
                    grant_req_d = 1'b0; pu_start_d = 1'b1; pu_first_d = (x_q == '0);
                    state_d = RUN_PU;
                end
            end
            RUN_PU: if (i_Partial_Output_Ready) begin
                grant_req_d = 1'b1;
                if (x_q < mu_q - MU_WIDTH'(1)) begin
                    x_d = x_q + MU_WIDTH'(1); state_d = REQ_RD;
                end else begin
                    state_d = REQ_WR;
                end
            end
            REQ_WR: if (i_Grant) begin
                state_d = STORE; count_d = '0; issue_done_d = 1'b0;
            end
            STORE: begin
                if (i_Grant && !issue_done_q) begin
                    rf_re_d = 1'b1; rf_addr_d = count_q;
                    if (count_q == LAST_ELEM) begin
                        count_d = '0; issue_done_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
                if (last_q) begin
                    grant_req_d = 1'b0; done_d = 1'b1; busy_d = 1'b0; state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= IDLE; row_q <= '0; col_q <= '0; mu_q <= '0; x_q <= '0;
            a_base_q <= '0; b_base_q <= '0; c_base_q <= '0;
            count_q <= '0; sel_q <= 1'b0; issue_done_q <= 1'b0;
            rd_elem_q <= '0; rd_sel_q <= 1'b0; rd_last_q <= 1'b0; last_q <= 1'b0;
            grant_req_q <= 1'b0; ack_q <= 1'b0; done_q <= 1'b0; busy_q <= 1'b0;
            rf_addr_q <= '0; rf_we_q <= 1'b0; rf_re_q <= 1'b0; aorb_q <= 1'b0;
            pu_start_q <= 1'b0; pu_first_q <= 1'b0;
            mem_re_q <= 1'b0; mem_we_q <= 1'b0; mem_addr_q <= '0;
        end else begin
            state_q <= state_d; row_q <= row_d; col_q <= col_d; mu_q <= mu_d; x_q <= x_d;
            a_base_q <= a_base_d; b_base_q <= b_base_d; c_base_q <= c_base_d;
            count_q <= count_d; sel_q <= sel_d; issue_done_q <= issue_done_d;
            rd_elem_q <= rd_elem_d; rd_sel_q <= rd_sel_d; rd_last_q <= rd_last_d; last_q <= last_d;
            grant_req_q <= grant_req_d; ack_q <= ack_d; done_q <= done_d; busy_q <= busy_d;
            rf_addr_q <= rf_addr_d; rf_we_q <= rf_we_d; rf_re_q <= rf_re_d; aorb_q <= aorb_d;
            pu_start_q <= pu_start_d; pu_first_q <= pu_first_d;
            mem_re_q <= mem_re_d; mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d;
        end
    end

    assign o_Grant_Request       = grant_req_q;
    assign o_Indexes_Received    = ack_q;
    assign o_Result_Ready        = done_q;
    assign o_Busy                = busy_q;
    assign o_RF_Address          = rf_addr_q;
    assign o_RF_Write_Enable     = rf_we_q;
    assign o_RF_Read_Enable      = rf_re_q;
    assign o_AorB                = aorb_q;
    assign o_PU_Start            = pu_start_q;
    assign o_PU_First            = pu_first_q;
    assign o_Memory_Read_Enable  = mem_re_q;
    assign o_Memory_Write_Enable = mem_we_q;
    assign o_Memory_Address      = mem_addr_q;

endmodule

// File: doc/tile_control_unit.md
TILE_CONTROL_UNIT -- requirements
Module: tile_control_unit

Interface
REQ-001 Parameters: K, 2, tile edge (tile = K*K elements); INDEX_WIDTH, 8, tile index width; MU_WIDTH, 8, tiles-per-dimension width; MEM_ADDR_WIDTH, 10, memory address width; CNT_WIDTH, clog2(K*K), element counter width.
REQ-002 Ports: i_Clock in 1 clock; i_Reset in 1 synchronous active-high reset.
REQ-003 i_Grant in 1 arbiter grant; o_Grant_Request out 1 held request.
REQ-004 i_Row_Index / i_Column_Index in INDEX_WIDTH tile i / j; i_Indexes_Ready in 1; o_Indexes_Received out 1 ack pulse; o_Result_Ready out 1 done pulse; o_Busy out 1.
REQ-005 i_mu in MU_WIDTH tiles per dimension; i_A_Base / i_B_Base / i_C_Base in MEM_ADDR_WIDTH matrix base addresses.
REQ-006 o_RF_Address out CNT_WIDTH; o_RF_Write_Enable out 1; o_RF_Read_Enable out 1; o_AorB out 1 (0=A, 1=B).
REQ-007 o_PU_Start out 1 pulse; o_PU_First out 1 (clear accumulator); i_Partial_Output_Ready in 1.
REQ-008 o_Memory_Read_Enable, o_Memory_Write_Enable out 1; o_Memory_Address out MEM_ADDR_WIDTH.

Function
REQ-009 States: IDLE, REQ_RD, LOAD, RUN_PU, REQ_WR, STORE; encoding in package.
REQ-010 IDLE: on i_Indexes_Ready latch i, j, mu (mu=0 treated as 1), bases; x<=0; o_Indexes_Received pulses 1 cycle; o_Busy=1 from next cycle; -> REQ_RD.
REQ-011 i_Indexes_Ready outside IDLE ignored, no ack.
REQ-012 REQ_RD: o_Grant_Request=1; on i_Grant -> LOAD, AorB=0, count=0.
REQ-013 LOAD: each cycle with i_Grant=1 assert o_Memory_Read_Enable, address = element(count) of A_ix (AorB=0) or B_xj (AorB=1), count++.
REQ-014 Memory read latency 1 cycle: o_RF_Write_Enable, o_RF_Address, o_AorB for element n asserted the cycle after its read.
REQ-015 Address: N=mu*K; element (r,c)=(count/K, count%K) of tile (p,q) -> base + (p*K+r)*N + q*K + c, modulo 2^MEM_ADDR_WIDTH.
REQ-016 Grant loss in LOAD/STORE: no new access issued, count holds, o_Grant_Request stays 1; in-flight element still completes; resume on regrant.
REQ-017 After K*K reads of A, switch to B without releasing request; after last B element written to RF, drop o_Grant_Request, pulse o_PU_Start with o_PU_First=(x==0), -> RUN_PU.
REQ-018 RUN_PU: wait i_Partial_Output_Ready; if x<mu-1: x++, -> REQ_RD; else -> REQ_WR.
REQ-019 REQ_WR: request; on grant -> STORE, count=0.
REQ-020 STORE: o_RF_Read_Enable with o_RF_Address=count; RF latency 1; o_Memory_Write_Enable with C_ij address of element n the following cycle.
REQ-021 After K*K writes: release request, o_Result_Ready pulse 1 cycle, o_Busy=0, -> IDLE.
REQ-022 i_Partial_Output_Ready outside RUN_PU ignored.

Reset
REQ-023 i_Reset at any cycle, including mid-burst: state IDLE, counters/x/latches 0, every output 0 next edge; in-flight accesses abandoned.

Structure
REQ-024 Shared package: state enum, AorB encoding, clog2 helper.
REQ-025 One sub-module tile_addr_gen: combinational base/tile/element -> address (REQ-015).

Verification
REQ-026 K=2, mu=1, i=j=0, bases 0/16/32 -> reads 0,1,2,3 then 16..19, one PU_Start with First=1, writes 32..35, Result_Ready once.
REQ-027 K=2, mu=2, A tile (1,0) -> A reads 8,9,12,13; B_xj x=1,j=1 base 16 -> 26,27,30,31.
REQ-028 mu=3 -> three load/PU rounds, PU_First=1 only first, one store burst.
REQ-029 Drop i_Grant 2 cycles after third A read -> no reads for 2 cycles, resume at element 3, no duplicate/missing RF write.
REQ-030 i_Reset during STORE element 2 -> all outputs 0 next cycle; new request completes normally.
REQ-031 i_Indexes_Ready pulsed in RUN_PU -> no ack, latched i, j unchanged.
